// File: rtl/alu_issue_unit.sv
// alu_issue_unit: decodes instruction fields to an ALU control code, holds ALU inputs for SETTLE_CYCLES, then registers result and flags.
// Define ALU_ILLEGAL_TRAP_EN to short-circuit illegal decodes to an out_err response without running the ALU.
module alu_issue_unit #(
   parameter int WIDTH = 8,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_op,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_carry,
   input  logic             alu_ovf,
`ifdef ALU_ILLEGAL_TRAP_EN
   output logic             out_err,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [2:0]       out_flags
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0] ctrl_q, ctrl_d, cnt_q, cnt_d, dec;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0] flags_q, flags_d;
   logic valid_q, valid_d, accept, trap;
`ifdef ALU_ILLEGAL_TRAP_EN
   logic err_q, err_d;
   assign trap = dec == 4'd15;
   assign out_err = err_q;
`else
   assign trap = 1'b0;
`endif
   assign accept = in_valid && in_ready;
   always_comb begin
      dec = alu_op == 2'b00 ? 4'd2 :
            alu_op == 2'b01 ? 4'd6 :
            alu_op == 2'b11 ? (funct3 == 3'b100 ? 4'd12 : 4'd15) :
            funct3 == 3'b000 ? (funct7b5 ? 4'd6 : 4'd2) :
            funct3 == 3'b111 ? 4'd0 :
            funct3 == 3'b110 ? 4'd1 :
            funct3 == 3'b010 ? 4'd7 : 4'd15;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = trap ? DONE : EXEC;
         EXEC:    if (cnt_q == 4'd0) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      in_ready = state_q == IDLE;
   end
   always_comb begin
      ctrl_d = ctrl_q;
      a_d = a_q;
      b_d = b_q;
      cnt_d = cnt_q;
      res_d = res_q;
      flags_d = flags_q;
      valid_d = valid_q;
`ifdef ALU_ILLEGAL_TRAP_EN
      err_d = err_q;
`endif
      if (accept) begin
         a_d = op_a;
         b_d = op_b;
         ctrl_d = trap ? ctrl_q : dec;
         cnt_d = 4'(SETTLE_CYCLES - 1);
         if (trap) begin
            valid_d = 1'b1;
            res_d = '0;
            flags_d = '0;
`ifdef ALU_ILLEGAL_TRAP_EN
            err_d = 1'b1;
`endif
         end
      end else if (state_q == EXEC) begin
         if (cnt_q == 4'd0) begin
            res_d = alu_result;
            flags_d = {alu_zero, alu_carry, alu_ovf};
            valid_d = 1'b1;
`ifdef ALU_ILLEGAL_TRAP_EN
            err_d = 1'b0;
`endif
         end else cnt_d = cnt_q - 4'd1;
      end else if (state_q == DONE && out_ready) valid_d = 1'b0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= '0;
         a_q <= '0;
         b_q <= '0;
         cnt_q <= '0;
         res_q <= '0;
         flags_q <= '0;
         valid_q <= 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
         err_q <= 1'b0;
`endif
      end else begin
         ctrl_q <= ctrl_d;
         a_q <= a_d;
         b_q <= b_d;
         cnt_q <= cnt_d;
         res_q <= res_d;
         flags_q <= flags_d;
         valid_q <= valid_d;
`ifdef ALU_ILLEGAL_TRAP_EN
         err_q <= err_d;
`endif
      end
   end
   assign alu_ctrl = ctrl_q;
   assign alu_a = a_q;
   assign alu_b = b_q;
   assign out_valid = valid_q;
   assign out_result = res_q;
   assign out_flags = flags_q;
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: randomized and directed requests against a behavioural model of the issue unit,
// with a bit-level 8-bit ALU standing in for the real one.
module tb_alu_issue_unit;
   localparam int SC = 4;
   logic clk = 0, rst = 1, in_valid = 0, funct7b5 = 0, out_ready = 0;
   logic [1:0] alu_op = 0;
   logic [2:0] funct3 = 0;
   logic [7:0] op_a = 0, op_b = 0;
   logic in_ready, out_valid, alu_zero, alu_carry, alu_ovf;
   logic [3:0] alu_ctrl;
   logic [7:0] alu_a, alu_b, alu_result, out_result;
   logic [2:0] out_flags;
`ifdef ALU_ILLEGAL_TRAP_EN
   logic out_err;
`endif
   int n_vec = 0, n_err = 0;
   logic [3:0] last_ctrl = 0;

   alu_issue_unit #(.WIDTH(8), .SETTLE_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5), .op_a(op_a), .op_b(op_b),
      .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
`ifdef ALU_ILLEGAL_TRAP_EN
      .out_err(out_err),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
   );

   always #5 clk = ~clk;

   logic [7:0] bb;
   logic [8:0] sum;
   logic sub, arith, ov;
   always_comb begin
      sub = alu_ctrl == 4'd6 || alu_ctrl == 4'd7;
      arith = alu_ctrl == 4'd2 || alu_ctrl == 4'd6;
      bb = sub ? ~alu_b : alu_b;
      sum = {1'b0, alu_a} + {1'b0, bb} + {8'b0, sub};
      ov = (alu_a[7] == bb[7]) && (sum[7] != alu_a[7]);
      alu_result = alu_ctrl == 4'd0 ? alu_a & alu_b :
                   alu_ctrl == 4'd1 ? alu_a | alu_b :
                   arith ? sum[7:0] :
                   alu_ctrl == 4'd7 ? {7'b0, sum[7] ^ ov} :
                   alu_ctrl == 4'd12 ? ~(alu_a | alu_b) : 8'h00;
      alu_zero = alu_result == 8'h00;
      alu_carry = arith && sum[8];
      alu_ovf = arith && ov;
   end

   function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3, input logic f7);
      if (op == 2'b00) return 4'd2;
      if (op == 2'b01) return 4'd6;
      if (op == 2'b11) return f3 == 3'b100 ? 4'd12 : 4'd15;
      case (f3)
         3'b000:  return f7 ? 4'd6 : 4'd2;
         3'b111:  return 4'd0;
         3'b110:  return 4'd1;
         3'b010:  return 4'd7;
         default: return 4'd15;
      endcase
   endfunction

   // {result, zero, carry, overflow} from plain integer arithmetic
   function automatic logic [10:0] ref_exec(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
      int ua, ub, sa, sb, r;
      bit cy, v;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      cy = 0;
      v = 0;
      case (c)
         4'd2: begin r = ua + ub; cy = r > 255; v = sa + sb > 127 || sa + sb < -128; end
         4'd6: begin r = ua - ub; cy = ua >= ub; v = sa - sb > 127 || sa - sb < -128; end
         4'd0: r = ua & ub;
         4'd1: r = ua | ub;
         4'd7: r = sa < sb ? 1 : 0;
         4'd12: r = 255 - (ua | ub);
         default: r = 0;
      endcase
      r = r & 255;
      return {8'(r), r == 0, cy, v};
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_alu_ctrl", alu_ctrl, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_flags", out_flags, 0);
`ifdef ALU_ILLEGAL_TRAP_EN
      check("rst_out_err", out_err, 0);
`endif
   endtask

   task automatic run_req(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                          input logic [7:0] a, input logic [7:0] b, input int stall);
      logic [3:0] c;
      logic [10:0] e;
      int lat;
      bit tr;
      c = ref_ctrl(op, f3, f7);
`ifdef ALU_ILLEGAL_TRAP_EN
      tr = c == 4'd15;
`else
      tr = 0;
`endif
      e = tr ? 11'd0 : ref_exec(c, a, b);
      alu_op = op;
      funct3 = f3;
      funct7b5 = f7;
      op_a = a;
      op_b = b;
      in_valid = 1;
      check("in_ready_idle", in_ready, 1);
      tick();
      in_valid = 0;
      if (!tr) last_ctrl = c;
      check("alu_ctrl", alu_ctrl, last_ctrl);
      if (!tr) begin
         check("in_ready_busy", in_ready, 0);
         check("alu_a", alu_a, a);
         check("alu_b", alu_b, b);
      end
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("latency", lat, tr ? 0 : SC);
      check("out_result", out_result, e[10:3]);
      check("out_flags", out_flags, e[2:0]);
`ifdef ALU_ILLEGAL_TRAP_EN
      check("out_err", out_err, tr);
`endif
      for (int i = 0; i < stall; i++) begin
         op_a = 8'($urandom);
         op_b = 8'($urandom);
         in_valid = 1;
         tick();
         check("stall_valid", out_valid, 1);
         check("stall_result", out_result, e[10:3]);
         check("stall_flags", out_flags, e[2:0]);
         check("stall_in_ready", in_ready, 0);
         if (!tr) check("stall_alu_a", alu_a, a);
         if (!tr) check("stall_alu_b", alu_b, b);
      end
      out_ready = 1;
      tick();
      out_ready = 0;
      in_valid = 0;
      check("out_valid_clr", out_valid, 0);
      check("in_ready_back", in_ready, 1);
      check("result_kept", out_result, e[10:3]);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_reset();
      rst = 0;
      tick();
      run_req(2'b10, 3'b000, 1'b0, 8'h7F, 8'h01, 0);
      run_req(2'b10, 3'b000, 1'b1, 8'h05, 8'h05, 0);
      run_req(2'b10, 3'b010, 1'b0, 8'h03, 8'h09, 0);
      run_req(2'b11, 3'b100, 1'b0, 8'hF0, 8'h0C, 0);
      run_req(2'b00, 3'b000, 1'b0, 8'h40, 8'h30, 5);
      run_req(2'b01, 3'b000, 1'b0, 8'h10, 8'h20, 0);
      run_req(2'b10, 3'b001, 1'b0, 8'h12, 8'h34, 2);
      run_req(2'b10, 3'b111, 1'b0, 8'hCA, 8'h0F, 0);
      // abort a transaction one cycle into EXEC
      alu_op = 2'b00;
      op_a = 8'h11;
      op_b = 8'h22;
      in_valid = 1;
      tick();
      in_valid = 0;
      tick();
      rst = 1;
      #1;
      check_reset();
      last_ctrl = 0;
      @(negedge clk);
      rst = 0;
      repeat (SC + 3) begin
         tick();
         check("no_valid_after_rst", out_valid, 0);
      end
      for (int i = 0; i < 60; i++)
         run_req(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Sequencer that drives the 8-bit RISC-V ALU from the instruction side.
- Accepts decoded instruction fields plus operands over a valid/ready handshake and decodes them to the ALU's 4-bit control code.
- Presents control and operands to the combinational ALU, holds them for a settle interval, then captures result and flags into an output register with its own valid/ready handshake.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU.
- SETTLE_CYCLES, 1, cycles ALU inputs are held before capture; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- alu_op  input  2  main-decoder ALUOp
- funct3  input  3  instruction funct3
- funct7b5  input  1  instruction bit 30
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- alu_ctrl  output  4  control code to ALU
- alu_a  output  WIDTH  operand A to ALU
- alu_b  output  WIDTH  operand B to ALU
- alu_result  input  WIDTH  ALU result
- alu_zero  input  1  ALU zero flag
- alu_carry  input  1  ALU carryout
- alu_ovf  input  1  ALU overflow
- out_valid  output  1  captured result available
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  captured result
- out_flags  output  3  captured {zero, carry, overflow}

Behaviour:
- Reset (async, rst=1): state IDLE; alu_ctrl=0, alu_a=0, alu_b=0, out_valid=0, out_result=0, out_flags=0, settle counter=0. in_ready=1 while in IDLE.
- in_ready = (state==IDLE), registered-state based with no combinational path from out_ready.
- Decode, registered at accept:
  - alu_op 00 -> 2 (add).
  - alu_op 01 -> 6 (sub).
  - alu_op 10 with funct3 000: funct7b5=0 -> 2; funct7b5=1 -> 6.
  - alu_op 10 with funct3 111 -> 0 (and); 110 -> 1 (or); 010 -> 7 (slt).
  - alu_op 11 with funct3 100 -> 12 (nor).
  - Any other combination is illegal -> 15. The ALU default yields result 0.
- FSM states IDLE, EXEC, DONE:
  - IDLE: on in_valid&&in_ready at an edge, load alu_a/alu_b from op_a/op_b, load alu_ctrl from decode, load counter=SETTLE_CYCLES-1, go EXEC. in_valid without accept has no effect.
  - EXEC: alu_ctrl/alu_a/alu_b held constant. If counter==0, capture alu_result into out_result and {alu_zero,alu_carry,alu_ovf} into out_flags, set out_valid=1, go DONE. Otherwise decrement the counter.
  - DONE: out_valid=1; out_result/out_flags stable. On out_ready=1 at an edge, clear out_valid and go IDLE; out_result/out_flags retain their values.
- Latency: accept at edge 0 -> out_valid high after edge SETTLE_CYCLES. Minimum request-to-request spacing is SETTLE_CYCLES+2 cycles with out_ready held high.
- alu_a/alu_b/alu_ctrl keep their last values in IDLE and DONE. They change only on accept.
- Flags pass through raw: the unit does not reinterpret carry/overflow per operation.
- Reset mid-EXEC or mid-DONE: immediate return to reset values; the pending result is discarded.
- Simultaneous in_valid in DONE is ignored (in_ready=0); the requester must hold in_valid.

Optional Feature:
- Macro: ALU_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port out_err (1 bit, reset 0).
  - An illegal decode skips EXEC: the accept edge goes straight to DONE with out_valid=1, out_result=0, out_flags=0, out_err=1. alu_ctrl is not updated.
  - Legal ops set out_err=0 at capture.
- Undefined:
  - No out_err port.
  - Illegal ops run through EXEC with alu_ctrl=15 and capture the ALU's output (result 0, zero=1).

Test Plan:
1. Add: alu_op=10, funct3=000, funct7b5=0, A=0x7F, B=0x01, out_ready=1 -> alu_ctrl=2; out_result=0x80, out_flags=ALU flags (overflow=1); out_valid after exactly SETTLE_CYCLES edges.
2. Sub with zero: alu_op=10, funct3=000, funct7b5=1, A=0x05, B=0x05 -> alu_ctrl=6, out_result=0x00, out_flags[2]=1.
3. SLT then NOR back-to-back: SLT with A=3, B=9 -> out_result=0x01. NOR via alu_op=11, funct3=100, A=0xF0, B=0x0C -> alu_ctrl=12, out_result=0x03. Second accept occurs no earlier than SETTLE_CYCLES+2 cycles after the first.
4. Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands held -> out_valid/out_result/out_flags stable, in_ready=0, alu_a/alu_b unchanged. On release, first result accepted, then the new request is accepted one cycle later.
5. Reset mid-EXEC with SETTLE_CYCLES=4: assert rst one cycle after accept -> all outputs 0 asynchronously, in_ready=1. After release no out_valid appears.
6. Illegal op: alu_op=10, funct3=001.
   - With ALU_ILLEGAL_TRAP_EN: out_valid after 1 edge, out_err=1, out_result=0, out_flags=0.
   - Without: alu_ctrl=15, out_result=0x00 after SETTLE_CYCLES edges.
